// File: rtl/spi_led_pkg.sv
// Shared constants and FSM state type for the SPI LED register slave.
package spi_led_pkg;

    localparam int unsigned DEFAULT_CMD_W  = 8;
    localparam int unsigned DEFAULT_DATA_W = 16;
    localparam int unsigned COUNT_W        = 5;

    localparam logic [DEFAULT_CMD_W-1:0] CMD_WRITE  = 8'h01;
    localparam logic [DEFAULT_CMD_W-1:0] CMD_READ   = 8'h02;
    localparam logic [DEFAULT_CMD_W-1:0] CMD_TOGGLE = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_SKIP
    } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchronizer for one SPI pin with single-cycle rise/fall pulses.
module spi_pin_sync #(
    parameter int unsigned STAGES     = 2,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{IDLE_LEVEL}};
            prev_q <= IDLE_LEVEL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_led_regslave.sv
// SPI mode-0 slave holding the LED image; all logic runs on clk, SPI pins are oversampled.
module spi_led_regslave
    import spi_led_pkg::*;
#(
    parameter int unsigned       SYNC_STAGES = 2,
    parameter int unsigned       DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned       CMD_W       = DEFAULT_CMD_W,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_cs,
    input  logic              cfg_sck,
    input  logic              cfg_si,
    output logic              cfg_so,
    output logic [DATA_W-1:0] data16,
    output logic              wr_strobe,
    output logic              frame_err
);

    localparam logic [COUNT_W-1:0] CMD_LAST   = COUNT_W'(CMD_W - 1);
    localparam logic [COUNT_W-1:0] FRAME_LAST = COUNT_W'(CMD_W + DATA_W - 1);

    logic cs_level, cs_rise, cs_fall;
    logic sck_rise, sck_fall, sck_level_unused;
    logic si_level, si_rise_unused, si_fall_unused;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .pin_i(cfg_cs),
        .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .pin_i(cfg_sck),
        .level_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_si (
        .clk(clk), .rst(rst), .pin_i(cfg_si),
        .level_o(si_level), .rise_o(si_rise_unused), .fall_o(si_fall_unused)
    );

    state_e               state_q;
    logic [COUNT_W-1:0]   count_q;
    logic [CMD_W-1:0]     cmd_q;
    logic [DATA_W-1:0]    rx_q;
    logic [DATA_W-1:0]    tx_q;
    logic [DATA_W-1:0]    data16_q;
    logic                 so_q;
    logic                 wr_q;
    logic                 err_q;
    logic [SYNC_STAGES-1:0] settle_q;
    logic                 armed_q;

    logic [CMD_W-1:0]     cmd_d;
    logic [DATA_W-1:0]    rx_d;
    logic                 cmd_known;

    assign cmd_d     = {cmd_q[CMD_W-2:0], si_level};
    assign rx_d      = {rx_q[DATA_W-2:0], si_level};
    assign cmd_known = (cmd_d == CMD_W'(CMD_WRITE)) || (cmd_d == CMD_W'(CMD_READ))
                    || (cmd_d == CMD_W'(CMD_TOGGLE));

    // The synchronizers reset to cs=1, so a CS already low when rst drops would
    // look like a falling edge. Frames are only accepted once a real high CS has
    // propagated through the sync chain (settle_q tracks that latency).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            cmd_q    <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            data16_q <= RESET_VALUE;
            so_q     <= 1'b0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            settle_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
            if (settle_q[SYNC_STAGES-1] && cs_level) begin
                armed_q <= 1'b1;
            end

            if (cs_rise) begin
                if ((state_q == ST_CMD && count_q != '0) || state_q == ST_DATA) begin
                    err_q <= 1'b1;
                end
                state_q <= ST_IDLE;
                count_q <= '0;
                so_q    <= 1'b0;
            end else if (cs_fall && armed_q) begin
                state_q <= ST_CMD;
                count_q <= '0;
                so_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: so_q <= 1'b0;
                    ST_CMD: begin
                        so_q <= 1'b0;
                        if (sck_rise) begin
                            cmd_q   <= cmd_d;
                            count_q <= count_q + 1'b1;
                            if (count_q == CMD_LAST) begin
                                if (cmd_known) begin
                                    state_q <= ST_DATA;
                                    tx_q    <= (cmd_d == CMD_W'(CMD_READ)) ? data16_q : '0;
                                end else begin
                                    state_q <= ST_SKIP;
                                    err_q   <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sck_rise) begin
                            rx_q    <= rx_d;
                            count_q <= count_q + 1'b1;
                            if (count_q == FRAME_LAST) begin
                                state_q <= ST_SKIP;
                                so_q    <= 1'b0;
                                if (cmd_q == CMD_W'(CMD_WRITE)) begin
                                    data16_q <= rx_d;
                                    wr_q     <= 1'b1;
                                end else if (cmd_q == CMD_W'(CMD_TOGGLE)) begin
                                    data16_q <= data16_q ^ rx_d;
                                    wr_q     <= 1'b1;
                                end
                            end
                        end else if (sck_fall) begin
                            so_q <= tx_q[DATA_W-1];
                            tx_q <= {tx_q[DATA_W-2:0], 1'b0};
                        end
                    end
                    ST_SKIP: so_q <= 1'b0;
                    default: begin
                        state_q <= ST_IDLE;
                        so_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cfg_so    = so_q;
    assign data16    = data16_q;
    assign wr_strobe = wr_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_spi_led_regslave.sv
// Randomized frame-level bench for spi_led_regslave against a command/length reference model.
module tb_spi_led_regslave;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_cs;
    logic        cfg_sck;
    logic        cfg_si;
    logic        cfg_so;
    logic [15:0] data16;
    logic        wr_strobe;
    logic        frame_err;

    always #5 clk = ~clk;

    spi_led_regslave #(
        .SYNC_STAGES(2),
        .DATA_W(16),
        .CMD_W(8),
        .RESET_VALUE(16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_cs(cfg_cs),
        .cfg_sck(cfg_sck),
        .cfg_si(cfg_si),
        .cfg_so(cfg_so),
        .data16(data16),
        .wr_strobe(wr_strobe),
        .frame_err(frame_err)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned wr_cnt   = 0;
    int unsigned err_cnt  = 0;
    logic [15:0] model;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_strobe) wr_cnt++;
            if (frame_err) err_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] mk(input logic [7:0] c, input logic [15:0] d,
                                       input logic [7:0] x, input int unsigned n);
        logic [39:0] full;
        full = {8'h00, c, d, x};
        return (n == 0) ? 40'h0 : (full >> (32 - n));
    endfunction

    // sck = clk/8: 4 clk low (si set, MISO captured), then 4 clk high
    task automatic clock_bits(input logic [39:0] payload, input int unsigned nbits,
                              output logic [39:0] cap, output logic [15:0] pre_last);
        cap      = '0;
        pre_last = data16;
        for (int unsigned i = 0; i < nbits; i++) begin
            cfg_si  = payload[nbits-1-i];
            cfg_sck = 1'b0;
            repeat (4) @(negedge clk);
            cap = {cap[38:0], cfg_so};
            if (i == 23) pre_last = data16;
            cfg_sck = 1'b1;
            repeat (4) @(negedge clk);
        end
        cfg_sck = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_frame(input logic [39:0] payload, input int unsigned nbits);
        logic [7:0]  cmd;
        logic [15:0] dat;
        logic [15:0] exp_data;
        logic [39:0] exp_cap;
        logic [39:0] cap;
        logic [15:0] pre_last;
        int unsigned exp_wr, exp_err, w0, e0, m;
        bit          valid;

        cmd      = (nbits >= 8) ? 8'(payload >> (nbits - 8)) : 8'h00;
        dat      = (nbits >= 24) ? 16'(payload >> (nbits - 24)) : 16'h0000;
        valid    = (cmd == 8'h01) || (cmd == 8'h02) || (cmd == 8'h03);
        exp_data = model;
        exp_wr   = 0;
        exp_err  = 0;
        exp_cap  = '0;
        if (nbits == 0) begin
            exp_err = 0;
        end else if (nbits < 8 || !valid) begin
            exp_err = 1;
        end else begin
            if (nbits < 24) exp_err = 1;
            else if (cmd == 8'h01) begin exp_data = dat; exp_wr = 1; end
            else if (cmd == 8'h03) begin exp_data = model ^ dat; exp_wr = 1; end
            if (cmd == 8'h02 && nbits > 8) begin
                m = (nbits >= 24) ? 16 : nbits - 8;
                exp_cap = (40'(model) >> (16 - m)) << (nbits - 8 - m);
            end
        end

        w0 = wr_cnt;
        e0 = err_cnt;
        cfg_cs = 1'b0;
        repeat (6) @(negedge clk);
        clock_bits(payload, nbits, cap, pre_last);
        cfg_cs = 1'b1;
        repeat (8) @(negedge clk);

        chk("data16", data16, exp_data);
        chk("wr_strobe_count", wr_cnt - w0, exp_wr);
        chk("frame_err_count", err_cnt - e0, exp_err);
        chk("miso_bits", cap, exp_cap);
        chk("miso_idle", cfg_so, 1'b0);
        if (nbits >= 24) chk("data16_before_last_rise", pre_last, model);
        model = exp_data;
    endtask

    initial begin
        logic [39:0] cap;
        logic [15:0] pre_last;
        int unsigned w0, e0, r, nb;
        logic [7:0]  c;

        rst     = 1'b1;
        cfg_cs  = 1'b1;
        cfg_sck = 1'b0;
        cfg_si  = 1'b0;
        model   = 16'h0000;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("reset_data16", data16, 16'h0000);
        chk("reset_wr_strobe", wr_strobe, 1'b0);
        chk("reset_frame_err", frame_err, 1'b0);
        chk("reset_cfg_so", cfg_so, 1'b0);

        run_frame(mk(8'h01, 16'hA53C, 8'h00, 24), 24);
        run_frame(mk(8'h02, 16'h0000, 8'h00, 24), 24);
        run_frame(mk(8'h01, 16'hFF00, 8'h00, 24), 24);
        run_frame(mk(8'h03, 16'h0F0F, 8'h00, 24), 24);
        run_frame(mk(8'h01, 16'h1111, 8'h00, 18), 18);
        run_frame(mk(8'h7E, 16'h5555, 8'h00, 24), 24);
        run_frame(mk(8'h01, 16'h1234, 8'hAA, 32), 32);
        run_frame(mk(8'h03, 16'hFFFF, 8'h00, 24), 24);
        run_frame(40'h0, 0);
        run_frame(mk(8'h02, 16'h0000, 8'h00, 5), 5);
        run_frame(mk(8'h02, 16'h0000, 8'h00, 14), 14);

        // Reset with CS held low mid-frame, then keep clocking.
        w0 = wr_cnt;
        e0 = err_cnt;
        cfg_cs = 1'b0;
        repeat (6) @(negedge clk);
        clock_bits(40'h01A, 12, cap, pre_last);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clock_bits(40'hBCD, 12, cap, pre_last);
        cfg_cs = 1'b1;
        repeat (8) @(negedge clk);
        model = 16'h0000;
        chk("midrst_data16", data16, 16'h0000);
        chk("midrst_wr_strobe_count", wr_cnt - w0, 0);
        chk("midrst_frame_err_count", err_cnt - e0, 0);
        run_frame(mk(8'h01, 16'hBEEF, 8'h00, 24), 24);

        for (int unsigned k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            c = (r < 3) ? 8'h01 : (r < 5) ? 8'h02 : (r < 8) ? 8'h03 : 8'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 32) : 24;
            run_frame(mk(c, 16'($urandom), 8'($urandom), nb), nb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
